// File: rtl/gpio_output_stage.sv
// Single-GPIO output stage: base level with atomic commands, one-shot pulse
// inversion, and registered pad drive for push-pull/open-drain/open-source.
module gpio_output_stage #(
  parameter int unsigned PulseCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [1:0]               mode_i,
  input  logic                     wr_i,
  input  logic                     wr_val_i,
  input  logic                     set_i,
  input  logic                     clr_i,
  input  logic                     toggle_i,
  input  logic                     pulse_start_i,
  input  logic [PulseCntWidth-1:0] pulse_len_i,
  output logic                     pulse_busy_o,
  output logic                     pulse_done_o,
  output logic                     value_o,
  output logic                     gpio_out_o,
  output logic                     gpio_oe_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_e;

  localparam logic [PulseCntWidth-1:0] CntOne = PulseCntWidth'(1);

  state_e                   state_q, state_d;
  logic [PulseCntWidth-1:0] cnt_q, cnt_d;
  logic                     base_q, base_d;
  logic                     done_d, level_d, out_d, oe_d;

  always_comb begin
    base_d = base_q;
    if (wr_i)          base_d = wr_val_i;
    else if (clr_i)    base_d = 1'b0;
    else if (set_i)    base_d = 1'b1;
    else if (toggle_i) base_d = ~base_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!en_i) begin
      // Disable aborts silently: no done strobe.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pulse_start_i) begin
            if (pulse_len_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = PULSE;
              cnt_d   = pulse_len_i;
            end
          end
        end
        PULSE: begin
          if (cnt_q == CntOne) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign level_d = base_d ^ (state_d == PULSE);

  always_comb begin
    out_d = 1'b0;
    oe_d  = 1'b0;
    if (en_i) begin
      case (mode_i)
        2'b01: begin out_d = level_d; oe_d = 1'b1;     end
        2'b10: begin out_d = 1'b0;    oe_d = ~level_d; end
        2'b11: begin out_d = 1'b1;    oe_d = level_d;  end
        default: begin out_d = 1'b0;  oe_d = 1'b0;     end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= 1'b0;
      value_o      <= 1'b0;
      gpio_out_o   <= 1'b0;
      gpio_oe_o    <= 1'b0;
      pulse_busy_o <= 1'b0;
      pulse_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      value_o      <= level_d;
      gpio_out_o   <= out_d;
      gpio_oe_o    <= oe_d;
      pulse_busy_o <= (state_d == PULSE);
      pulse_done_o <= done_d;
    end
  end

endmodule

// File: tb/tb_gpio_output_stage.sv
// Table-driven bench for gpio_output_stage; expected outputs are queued when
// each cycle's stimulus is driven and compared one cycle later.
module tb_gpio_output_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, wr_i, wr_val_i, set_i, clr_i, toggle_i, pulse_start_i;
  logic [1:0]  mode_i;
  logic [15:0] pulse_len_i;
  logic        pulse_busy_o, pulse_done_o, value_o, gpio_out_o, gpio_oe_o;

  gpio_output_stage #(.PulseCntWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
    .wr_i(wr_i), .wr_val_i(wr_val_i), .set_i(set_i), .clr_i(clr_i),
    .toggle_i(toggle_i), .pulse_start_i(pulse_start_i), .pulse_len_i(pulse_len_i),
    .pulse_busy_o(pulse_busy_o), .pulse_done_o(pulse_done_o), .value_o(value_o),
    .gpio_out_o(gpio_out_o), .gpio_oe_o(gpio_oe_o)
  );

  always #5 clk_i = ~clk_i;

  // cmd = {wr, wr_val, set, clr, toggle}; exp = {value, out, oe, busy, done}
  localparam logic [4:0] NONE = 5'b00000, SET = 5'b00100, CLR = 5'b00010,
                         TOG = 5'b00001, WR0 = 5'b10000, WR1 = 5'b11000;

  typedef struct {
    string       name;
    logic        rst, en;
    logic [1:0]  mode;
    logic [4:0]  cmd;
    logic        ps;
    logic [15:0] plen;
    logic [4:0]  exp;
  } vec_t;

  vec_t        tbl[$];
  logic [4:0]  sb[$];
  string       nm[$];
  int unsigned checks = 0, passed = 0;

  function automatic vec_t v(input string name, input logic rst, input logic en,
                             input logic [1:0] mode, input logic [4:0] cmd,
                             input logic ps, input logic [15:0] plen,
                             input logic [4:0] exp);
    vec_t r;
    r.name = name; r.rst = rst; r.en = en; r.mode = mode; r.cmd = cmd;
    r.ps = ps; r.plen = plen; r.exp = exp;
    return r;
  endfunction

  task automatic apply(input vec_t t);
    logic [4:0] e, act;
    string      n;
    rst_i = t.rst; en_i = t.en; mode_i = t.mode;
    {wr_i, wr_val_i, set_i, clr_i, toggle_i} = t.cmd;
    pulse_start_i = t.ps; pulse_len_i = t.plen;
    sb.push_back(t.exp);
    nm.push_back(t.name);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    n = nm.pop_front();
    act = {value_o, gpio_out_o, gpio_oe_o, pulse_busy_o, pulse_done_o};
    checks++;
    if (act === e) passed++;
    else $display("FAIL %s: got val/out/oe/busy/done=%b, expected %b", n, act, e);
  endtask

  initial begin
    // Basic commands, priority and pad modes.
    tbl.push_back(v("reset",          1, 0, 2'b00, NONE,            0, 0, 5'b00000));
    tbl.push_back(v("reset_priority", 1, 1, 2'b01, SET,             1, 3, 5'b00000));
    tbl.push_back(v("pp_set",         0, 1, 2'b01, SET,             0, 0, 5'b11100));
    tbl.push_back(v("pp_clr",         0, 1, 2'b01, CLR,             0, 0, 5'b00100));
    tbl.push_back(v("pp_set2",        0, 1, 2'b01, SET,             0, 0, 5'b11100));
    tbl.push_back(v("wr_wins",        0, 1, 2'b01, WR0 | SET | TOG, 0, 0, 5'b00100));
    tbl.push_back(v("pp_set3",        0, 1, 2'b01, SET,             0, 0, 5'b11100));
    tbl.push_back(v("clr_beats_set",  0, 1, 2'b01, SET | CLR,       0, 0, 5'b00100));
    tbl.push_back(v("toggle",         0, 1, 2'b01, TOG,             0, 0, 5'b11100));
    tbl.push_back(v("set_beats_tog",  0, 1, 2'b01, SET | TOG,       0, 0, 5'b11100));
    tbl.push_back(v("wr1_beats_clr",  0, 1, 2'b01, WR1 | CLR,       0, 0, 5'b11100));
    tbl.push_back(v("clr_beats_tog",  0, 1, 2'b01, CLR | TOG,       0, 0, 5'b00100));
    tbl.push_back(v("od_low",         0, 1, 2'b10, NONE,            0, 0, 5'b00100));
    tbl.push_back(v("od_release",     0, 1, 2'b10, SET,             0, 0, 5'b10000));
    tbl.push_back(v("os_high",        0, 1, 2'b11, NONE,            0, 0, 5'b11100));
    tbl.push_back(v("os_release",     0, 1, 2'b11, CLR,             0, 0, 5'b01000));
    tbl.push_back(v("mode_off",       0, 1, 2'b00, SET,             0, 0, 5'b10000));
    tbl.push_back(v("en_off",         0, 0, 2'b01, NONE,            0, 0, 5'b10000));
    tbl.push_back(v("cmd_while_off",  0, 0, 2'b01, CLR,             0, 0, 5'b00000));
    tbl.push_back(v("start_while_off",0, 0, 2'b01, NONE,            1, 0, 5'b00000));
    tbl.push_back(v("pp_base0",       0, 1, 2'b01, NONE,            0, 0, 5'b00100));

    rst_i = 1; en_i = 0; mode_i = 0; {wr_i, wr_val_i, set_i, clr_i, toggle_i} = NONE;
    pulse_start_i = 0; pulse_len_i = 0;
    foreach (tbl[i]) apply(tbl[i]);

    // Pulse of 5 with a restart attempt at n+2.
    apply(v("p5_n1", 0, 1, 2'b01, NONE, 1, 5, 5'b11110));
    apply(v("p5_n2", 0, 1, 2'b01, NONE, 0, 0, 5'b11110));
    apply(v("p5_n3", 0, 1, 2'b01, NONE, 1, 2, 5'b11110));
    apply(v("p5_n4", 0, 1, 2'b01, NONE, 0, 0, 5'b11110));
    apply(v("p5_n5", 0, 1, 2'b01, NONE, 0, 0, 5'b11110));
    apply(v("p5_done", 0, 1, 2'b01, NONE, 0, 0, 5'b00101));
    apply(v("p5_after", 0, 1, 2'b01, NONE, 0, 0, 5'b00100));

    // Zero-length pulse: done strobe only.
    apply(v("p0_done",  0, 1, 2'b01, NONE, 1, 0, 5'b00101));
    apply(v("p0_after", 0, 1, 2'b01, NONE, 0, 0, 5'b00100));

    // Pulse of 10 aborted by en_i low at n+4.
    for (int i = 0; i < 4; i++)
      apply(v("p10_active", 0, 1, 2'b01, NONE, (i == 0), 10, 5'b11110));
    apply(v("p10_abort", 0, 0, 2'b01, NONE, 0, 0, 5'b00000));
    for (int i = 0; i < 8; i++)
      apply(v("p10_no_done", 0, 0, 2'b01, NONE, 0, 0, 5'b00000));
    apply(v("p10_reenable", 0, 1, 2'b01, NONE, 0, 0, 5'b00100));

    // Base command mid-pulse keeps the inversion relative to the new base.
    apply(v("p3_start",  0, 1, 2'b01, NONE, 1, 3, 5'b11110));
    apply(v("p3_set",    0, 1, 2'b01, SET,  0, 0, 5'b00110));
    apply(v("p3_hold",   0, 1, 2'b01, NONE, 0, 0, 5'b00110));
    apply(v("p3_done",   0, 1, 2'b01, NONE, 0, 0, 5'b11101));

    // Reset mid-pulse with base=1, then a normal pulse of 3.
    apply(v("rp_start",  0, 1, 2'b01, NONE, 1, 4, 5'b00110));
    apply(v("rp_hold",   0, 1, 2'b01, NONE, 0, 0, 5'b00110));
    apply(v("rp_reset",  1, 1, 2'b01, NONE, 0, 0, 5'b00000));
    apply(v("rp_p1",     0, 1, 2'b01, NONE, 1, 3, 5'b11110));
    apply(v("rp_p2",     0, 1, 2'b01, NONE, 0, 0, 5'b11110));
    apply(v("rp_p3",     0, 1, 2'b01, NONE, 0, 0, 5'b11110));
    apply(v("rp_done",   0, 1, 2'b01, NONE, 0, 0, 5'b00101));
    apply(v("rp_after",  0, 1, 2'b01, NONE, 0, 0, 5'b00100));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish within 100000 time units");
    $fatal(1);
  end

endmodule
